// File: rtl/sodor_mem_pkg.sv
// ============================================================================
// sodor_mem_pkg : shared types and helpers for the Sodor scratchpad path
// Rev 1.0
// ============================================================================
`default_nettype none

package sodor_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_e;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    // Full 32-bit word offset; callers truncate to their RAM depth, so
    // out-of-range addresses simply wrap.
    function automatic logic [31:0] addr_to_word(input logic [31:0] addr,
                                                 input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sodor_arb_starve_ctr.sv
// ============================================================================
// sodor_arb_starve_ctr : saturating imem wait counter and force-imem compare
// Rev 1.0
// ============================================================================
`default_nettype none

module sodor_arb_starve_ctr #(
    parameter int MAX_WAIT   = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic imem_valid,
    input  logic imem_grant,
    output logic force_imem
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!imem_valid || imem_grant) begin
            cnt_d = 4'd0;
        end else if (cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_imem = !FIXED_PRIO && (cnt_q >= 4'(MAX_WAIT));

endmodule

`default_nettype wire

// File: rtl/sodor_scratchpad_arbiter.sv
// ============================================================================
// sodor_scratchpad_arbiter : imem/dmem sharing of one single-port scratchpad
// Rev 1.0
// ============================================================================
`default_nettype none

module sodor_scratchpad_arbiter
    import sodor_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          ADDR_W     = 10,
    parameter int          MAX_WAIT   = 4,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_imem_req_valid,
    output logic              io_imem_req_ready,
    input  logic [31:0]       io_imem_req_bits_addr,
    output logic              io_imem_resp_valid,
    output logic [31:0]       io_imem_resp_bits_data,
    input  logic              io_dmem_req_valid,
    output logic              io_dmem_req_ready,
    input  logic [31:0]       io_dmem_req_bits_addr,
    input  logic              io_dmem_req_bits_fcn,
    input  logic [3:0]        io_dmem_req_bits_mask,
    input  logic [31:0]       io_dmem_req_bits_data,
    output logic              io_dmem_resp_valid,
    output logic [31:0]       io_dmem_resp_bits_data,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic              w_force_imem;
    logic              w_imem_grant;
    logic              w_dmem_grant;
    logic [ADDR_W-1:0] w_imem_idx;
    logic [ADDR_W-1:0] w_dmem_idx;
    owner_e            owner_q, owner_d;
    logic              store_q, store_d;

    sodor_arb_starve_ctr #(
        .MAX_WAIT   (MAX_WAIT),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_starve (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (io_imem_req_valid),
        .imem_grant (w_imem_grant),
        .force_imem (w_force_imem)
    );

    // Grants are gated by reset so the RAM port stays quiet while held.
    assign w_dmem_grant = !reset && io_dmem_req_valid
                        && !(io_imem_req_valid && w_force_imem);
    assign w_imem_grant = !reset && io_imem_req_valid && !w_dmem_grant;

    assign w_imem_idx = ADDR_W'(addr_to_word(io_imem_req_bits_addr, BASE_ADDR));
    assign w_dmem_idx = ADDR_W'(addr_to_word(io_dmem_req_bits_addr, BASE_ADDR));

    assign io_imem_req_ready = w_imem_grant;
    assign io_dmem_req_ready = w_dmem_grant;

    assign mem_en    = w_imem_grant || w_dmem_grant;
    assign mem_addr  = w_imem_grant ? w_imem_idx : w_dmem_idx;
    assign mem_wdata = io_dmem_req_bits_data;
    assign mem_we    = (w_dmem_grant && (io_dmem_req_bits_fcn == M_XWR))
                     ? io_dmem_req_bits_mask : 4'b0000;

    always_comb begin
        owner_d = OWN_NONE;
        store_d = 1'b0;
        if (w_imem_grant) begin
            owner_d = OWN_IMEM;
        end else if (w_dmem_grant) begin
            owner_d = OWN_DMEM;
            store_d = (io_dmem_req_bits_fcn == M_XWR);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            store_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            store_q <= store_d;
        end
    end

    assign io_imem_resp_valid     = (owner_q == OWN_IMEM);
    assign io_imem_resp_bits_data = (owner_q == OWN_IMEM) ? mem_rdata : 32'h0;
    assign io_dmem_resp_valid     = (owner_q == OWN_DMEM);
    assign io_dmem_resp_bits_data = ((owner_q == OWN_DMEM) && !store_q)
                                  ? mem_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_sodor_scratchpad_arbiter.sv
// ============================================================================
// tb_sodor_scratchpad_arbiter : directed self-checking bench for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sodor_scratchpad_arbiter;

    logic        clock;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic        dmem_fcn;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_wdata;

    logic        a_imem_ready, a_imem_rvalid, a_dmem_ready, a_dmem_rvalid;
    logic [31:0] a_imem_rdata, a_dmem_rdata;
    logic        a_mem_en;
    logic [3:0]  a_mem_we;
    logic [9:0]  a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;

    logic        b_imem_ready, b_imem_rvalid, b_dmem_ready, b_dmem_rvalid;
    logic [31:0] b_imem_rdata, b_dmem_rdata;
    logic        b_mem_en;
    logic [3:0]  b_mem_we;
    logic [9:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    logic [31:0] ram [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    sodor_scratchpad_arbiter #(.FIXED_PRIO(1'b0)) dut_a (
        .clock(clock), .reset(reset),
        .io_imem_req_valid(imem_valid), .io_imem_req_ready(a_imem_ready),
        .io_imem_req_bits_addr(imem_addr),
        .io_imem_resp_valid(a_imem_rvalid), .io_imem_resp_bits_data(a_imem_rdata),
        .io_dmem_req_valid(dmem_valid), .io_dmem_req_ready(a_dmem_ready),
        .io_dmem_req_bits_addr(dmem_addr), .io_dmem_req_bits_fcn(dmem_fcn),
        .io_dmem_req_bits_mask(dmem_mask), .io_dmem_req_bits_data(dmem_wdata),
        .io_dmem_resp_valid(a_dmem_rvalid), .io_dmem_resp_bits_data(a_dmem_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    sodor_scratchpad_arbiter #(.FIXED_PRIO(1'b1)) dut_b (
        .clock(clock), .reset(reset),
        .io_imem_req_valid(imem_valid), .io_imem_req_ready(b_imem_ready),
        .io_imem_req_bits_addr(imem_addr),
        .io_imem_resp_valid(b_imem_rvalid), .io_imem_resp_bits_data(b_imem_rdata),
        .io_dmem_req_valid(dmem_valid), .io_dmem_req_ready(b_dmem_ready),
        .io_dmem_req_bits_addr(dmem_addr), .io_dmem_req_bits_fcn(dmem_fcn),
        .io_dmem_req_bits_mask(dmem_mask), .io_dmem_req_bits_data(dmem_wdata),
        .io_dmem_resp_valid(b_dmem_rvalid), .io_dmem_resp_bits_data(b_dmem_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    assign b_mem_rdata = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scratchpad model for dut_a; reloaded with known words during reset.
    always @(posedge clock) begin
        if (reset) begin
            ram[0] <= 32'h1234_5678;
            ram[1] <= 32'h0000_0013;
        end else if (a_mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mem_we[b]) ram[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            end
            a_mem_rdata <= ram[a_mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic fcn, input logic [3:0] mask,
                       input logic [31:0] wd);
        @(negedge clock);
        imem_valid = iv;
        imem_addr  = ia;
        dmem_valid = dv;
        dmem_addr  = da;
        dmem_fcn   = fcn;
        dmem_mask  = mask;
        dmem_wdata = wd;
        #1;
    endtask

    logic exp_i, prev_i;

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0; imem_addr = 32'h0;
        dmem_valid = 1'b0; dmem_addr = 32'h0;
        dmem_fcn = 1'b0; dmem_mask = 4'h0; dmem_wdata = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("rst_imem_rvalid", a_imem_rvalid, 0);
        check("rst_dmem_rvalid", a_dmem_rvalid, 0);
        check("rst_dmem_rdata", a_dmem_rdata, 0);
        check("rst_mem_en", a_mem_en, 0);
        check("rst_mem_we", a_mem_we, 0);
        reset = 1'b0;

        // imem-only fetch of word 1
        cyc(1, 32'h8000_0004, 0, 0, 0, 0, 0);
        check("f1_imem_rdy", a_imem_ready, 1);
        check("f1_dmem_rdy", a_dmem_ready, 0);
        check("f1_mem_addr", a_mem_addr, 1);
        check("f1_mem_we", a_mem_we, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("f1_resp_valid", a_imem_rvalid, 1);
        check("f1_resp_data", a_imem_rdata, 32'h0000_0013);
        check("f1_dmem_rvalid", a_dmem_rvalid, 0);
        check("f1_idle_mem_en", a_mem_en, 0);

        // fetch wraps to word 0
        cyc(1, 32'h8000_1000, 0, 0, 0, 0, 0);
        check("wrap_mem_addr", a_mem_addr, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("wrap_resp_data", a_imem_rdata, 32'h1234_5678);

        // partial store then load of the same word
        cyc(0, 0, 1, 32'h8000_1000, 1, 4'b0011, 32'hAABB_CCDD);
        check("st_dmem_rdy", a_dmem_ready, 1);
        check("st_mem_we", a_mem_we, 4'b0011);
        check("st_mem_addr", a_mem_addr, 0);
        check("st_mem_wdata", a_mem_wdata, 32'hAABB_CCDD);
        cyc(0, 0, 1, 32'h8000_1000, 0, 4'b1111, 32'h0);
        check("st_resp_valid", a_dmem_rvalid, 1);
        check("st_resp_data", a_dmem_rdata, 0);
        check("ld_mem_we", a_mem_we, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("ld_resp_valid", a_dmem_rvalid, 1);
        check("ld_resp_data", a_dmem_rdata, 32'h1234_CCDD);

        // both requesting every cycle; dmem stores to word 2
        for (int k = 0; k < 20; k++) begin
            cyc(1, 32'h8000_0000, 1, 32'h8000_0008, 1, 4'hF, 32'hCAFE_0000 + k);
            exp_i = ((k % 5) == 4);
            check("stv_imem_rdy", a_imem_ready, exp_i);
            check("stv_dmem_rdy", a_dmem_ready, !exp_i);
            check("stv_mem_we", a_mem_we, exp_i ? 4'h0 : 4'hF);
            check("stv_mem_addr", a_mem_addr, exp_i ? 0 : 2);
            check("fix_imem_rdy", b_imem_ready, 0);
            check("fix_dmem_rdy", b_dmem_ready, 1);
            if (k > 0) begin
                prev_i = (((k - 1) % 5) == 4);
                check("stv_imem_rvalid", a_imem_rvalid, prev_i);
                check("stv_dmem_rvalid", a_dmem_rvalid, !prev_i);
                if (prev_i) check("stv_imem_rdata", a_imem_rdata, 32'h1234_CCDD);
                else        check("stv_dmem_rdata", a_dmem_rdata, 0);
            end
        end
        cyc(0, 0, 1, 32'h8000_0008, 0, 0, 0);
        check("fix_cnt_sat", {28'h0, dut_b.u_starve.cnt_q}, 15);
        check("stv_last_imem", a_imem_rvalid, 1);
        check("stv_last_idata", a_imem_rdata, 32'h1234_CCDD);
        check("ld2_dmem_rdy", a_dmem_ready, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("ld2_resp_data", a_dmem_rdata, 32'hCAFE_0012);

        // reset lands before the load's response can appear
        cyc(0, 0, 1, 32'h8000_0004, 0, 0, 0);
        check("rmid_dmem_rdy", a_dmem_ready, 1);
        #2 reset = 1'b1;
        #1;
        check("rmid_mem_en", a_mem_en, 0);
        check("rmid_dmem_rdy0", a_dmem_ready, 0);
        @(posedge clock); #1;
        check("rmid_rvalid", a_dmem_rvalid, 0);
        check("rmid_rdata", a_dmem_rdata, 0);
        check("rmid_mem_we", a_mem_we, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        dmem_valid = 1'b0;
        #1;
        check("rpost_rvalid", a_dmem_rvalid, 0);
        cyc(1, 32'h8000_0004, 0, 0, 0, 0, 0);
        check("rpost_imem_rdy", a_imem_ready, 1);
        check("rpost_mem_addr", a_mem_addr, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("rpost_resp_valid", a_imem_rvalid, 1);
        check("rpost_resp_data", a_imem_rdata, 32'h0000_0013);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
